// File: rtl/video_scanout.sv
// video_scanout: raster timing generator with sprite-over-background merge
// and a registered RGB/sync/DE output stage.
module video_scanout #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_v_sync,
  input  logic [7:0]  i_spr_red,
  input  logic [7:0]  i_spr_green,
  input  logic [7:0]  i_spr_blue,
  input  logic        i_sprite_hit,
  input  logic [7:0]  i_bg_red,
  input  logic [7:0]  i_bg_green,
  input  logic [7:0]  i_bg_blue,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [23:0] rgb_q, rgb_d;
  logic        de_q, hs_q, vs_q, h_wrap, active, hs_raw, vs_raw;
  always_comb begin
    h_wrap  = h_cnt_q == 16'(H_TOTAL - 1);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 16'd1;
    v_cnt_d = !h_wrap ? v_cnt_q : (v_cnt_q == 16'(V_TOTAL - 1)) ? '0 : v_cnt_q + 16'd1;
    active  = (h_cnt_q < 16'(H_ACTIVE)) && (v_cnt_q < 16'(V_ACTIVE));
    hs_raw  = (h_cnt_q >= 16'(H_ACTIVE + H_FP)) && (h_cnt_q < 16'(H_ACTIVE + H_FP + H_SYNC));
    vs_raw  = (v_cnt_q >= 16'(V_ACTIVE + V_FP)) && (v_cnt_q < 16'(V_ACTIVE + V_FP + V_SYNC));
    // Sprite colour is only selected on a hit, so undefined sprite data never leaks through.
    rgb_d   = !active ? 24'd0 :
              i_sprite_hit ? {i_spr_red, i_spr_green, i_spr_blue} :
                             {i_bg_red, i_bg_green, i_bg_blue};
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      rgb_q   <= rgb_d;
      de_q    <= active;
      hs_q    <= hs_raw ? SYNC_POL : ~SYNC_POL;
      vs_q    <= vs_raw ? SYNC_POL : ~SYNC_POL;
    end
  end
  assign o_x      = h_cnt_q;
  assign o_y      = v_cnt_q;
  assign o_v_sync = (h_cnt_q == 16'd0) && (v_cnt_q == 16'(V_ACTIVE));
  assign {o_red, o_green, o_blue} = rgb_q;
  assign o_de     = de_q;
  assign o_hsync  = hs_q;
  assign o_vsync  = vs_q;
endmodule
